udma_rx_aligner: RTL and testbench
==================================

Name: udma_rx_aligner

Overview:
- Parametrised successor of the uDMA HyperBus/PSRAM RX width adapter; sits between the PHY RX stream and the uDMA RX FIFO.
- Packs PHY beats of PHY_W bits into 32-bit uDMA words and discards any byte start offset (0..3), not just odd addresses.
- Optionally byte-swaps each beat and zero-pads the final partial word; drops PHY bytes beyond the programmed size.
- Full valid/ready on both sides with a registered output stage.

Parameters:
- TRANS_SIZE, 16, width of byte-count config and internal counters.
- PHY_W, 16, PHY beat width in bits; legal values 8, 16, 32. PHY_B = PHY_W/8.
- SWAP_DEF, 0, reset value of the internal swap-mode register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- cfg_start_i  in  1  one-cycle pulse; latches cfg_* and starts a transfer; ignored while busy_o=1.
- cfg_rx_size_i  in  TRANS_SIZE  transfer length in bytes.
- cfg_offset_i  in  2  leading bytes to discard from the first PHY beats.
- cfg_swap_i  in  1  reverse byte order within each PHY beat before packing.
- src_valid_i  in  1  PHY beat valid.
- src_ready_o  out  1  beat accepted when src_valid_i & src_ready_o.
- src_data_i  in  PHY_W  PHY beat; byte 0 = bits [7:0] = lowest address.
- dst_valid_o  out  1  output word valid.
- dst_ready_i  in  1  uDMA FIFO ready.
- dst_data_o  out  32  packed word; lowest address in [7:0].
- dst_last_o  out  1  qualifies the final word of the transfer.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset: dst_valid_o=0, dst_data_o=0, dst_last_o=0, src_ready_o=0, busy_o=0, done_o=0; accumulator empty; FSM=IDLE; swap register=SWAP_DEF.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: on cfg_start_i, latch size/offset/swap; set skip=offset, rem=size, fill=0.
  - size!=0: go to RUN.
  - size=0: assert done_o the next cycle and stay in IDLE; no output word.
- Accumulator: ACC_B=4+PHY_B bytes, shift register, byte fill count `fill`.
- src_ready_o=1 in RUN iff fill+PHY_B <= ACC_B (registered, no combinational path from dst_ready_i).
- Accepted beat, after optional swap:
  - Drop the first min(skip,PHY_B) bytes and decrement skip by that amount.
  - Append the next min(remaining beat bytes, rem - fill_pending) bytes at position `fill`.
  - Discard the rest.
  - Offset > PHY_B spans multiple beats (e.g. PHY_W=8, offset=3 drops three whole beats).
- Word emission: when fill>=4 or (bytes received == size and fill>0), and the output register is empty or handshaking this cycle:
  - Load the lower 4 bytes into dst_data_o.
  - Zero-pad bytes beyond fill.
  - Shift the accumulator down by 4 and decrement rem by the bytes moved.
- dst_last_o=1 with the word that makes rem reach 0.
- Latency: beat accepted at cycle N, word visible at N+1 at the earliest.
- Throughput: one word per cycle when PHY_W=32; source never stalls on PHY bandwidth.
- Output register: holds data/last stable while dst_valid_o & !dst_ready_i; a same-cycle consume and refill is allowed.
- RUN -> DRAIN once all size bytes are received; src_ready_o=0 in DRAIN. Further PHY beats are not accepted; the controller stops the PHY.
- DRAIN -> IDLE on the handshake of the word with dst_last_o; done_o pulses that cycle +1; busy_o falls with done_o.
- Simultaneous events:
  - Emission and beat acceptance in the same cycle: fill += appended - 4.
  - cfg_start_i in the cycle done_o pulses: accepted, because busy_o is already 0.
- Reset mid-transfer: all state clears immediately and asynchronously; partial data is lost and no done_o pulse occurs.
- Counters are TRANS_SIZE wide with no wrap. Max size is 2^TRANS_SIZE-1 bytes.

Optional Feature:
- Macro UDMA_RX_ALIGNER_ABORT_EN.
- With the macro:
  - Extra input cfg_abort_i (1 bit). A pulse in RUN or DRAIN clears the accumulator, drops dst_valid_o, returns to IDLE the next cycle and pulses done_o.
  - Extra output abort_o (1 bit), pulsed together with that done_o.
- Without the macro: neither port exists; the transfer always runs to completion.

Test Plan:
- PHY_W=16, size=8, offset=0, beats 0x1100,0x3322,0x5544,0x7766 -> words 0x33221100, 0x77665544(last); done_o one cycle after the second handshake.
- PHY_W=16, size=5, offset=1, beats 0x1100,0x3322,0x5544,0x7766 -> 0x44332211, 0x00000055(last); src_ready_o drops after the third beat.
- PHY_W=8, size=3, offset=3, bytes 0xA0..0xA6 -> 0x00A5A4A3(last); the first three beats are dropped.
- PHY_W=32, size=12, swap=1, beats 0x00112233,0x44556677,0x8899AABB with dst_ready_i low for 5 cycles on word 2 -> 0x33221100, 0x77665544 (held stable), 0xBBAA9988(last).
- size=0 start -> done_o next cycle, no dst_valid_o; reset asserted mid-transfer -> all outputs 0, busy_o=0 and no done_o.
- ABORT_EN: abort after the first word of size=16 -> dst_valid_o low next cycle, abort_o/done_o pulse, a new transfer works.

Source files
------------

// File: rtl/udma_rx_aligner.sv
// rtl/udma_rx_aligner.sv - packs PHY RX beats into 32-bit uDMA words with offset skip, byte swap and size trim
// Optional abort port pair (cfg_abort_i / abort_o): define UDMA_RX_ALIGNER_ABORT_EN
module udma_rx_aligner #(
  parameter int TRANS_SIZE = 16,
  parameter int PHY_W      = 16,
  parameter bit SWAP_DEF   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [TRANS_SIZE-1:0] cfg_rx_size_i,
  input  logic [1:0]            cfg_offset_i,
  input  logic                  cfg_swap_i,
`ifdef UDMA_RX_ALIGNER_ABORT_EN
  input  logic                  cfg_abort_i,
  output logic                  abort_o,
`endif
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [PHY_W-1:0]      src_data_i,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [31:0]           dst_data_o,
  output logic                  dst_last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int         PHY_B  = PHY_W / 8;
  localparam int         ACC_B  = 4 + PHY_B;
  localparam int         ACC_W  = 8 * ACC_B;
  localparam logic [2:0] PHY_BL = 3'(PHY_B);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [ACC_W-1:0]      acc, acc_app, acc_nx;
  logic [3:0]            fill, total, moved, fill_nx;
  logic [1:0]            skip;
  logic [2:0]            drop, avail, app;
  logic [TRANS_SIZE-1:0] to_recv, recv_nx, rem;
  logic [PHY_W-1:0]      beat, beat_sh;
  logic                  swap_q, accept, emit, last_w, done_nx, start_ok, abort_hit;

`ifdef UDMA_RX_ALIGNER_ABORT_EN
  assign abort_hit = cfg_abort_i && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Swap and trim the incoming beat, append it behind the buffered bytes, decide on a word this cycle
  always_comb begin
    beat = src_data_i;
    if (swap_q) begin
      for (int b = 0; b < PHY_B; b++) beat[8*b +: 8] = src_data_i[8*(PHY_B-1-b) +: 8];
    end
    accept  = src_valid_i & src_ready_o;
    drop    = ({1'b0, skip} < PHY_BL) ? {1'b0, skip} : PHY_BL;
    avail   = PHY_BL - drop;
    app     = 3'd0;
    if (accept) app = (to_recv < TRANS_SIZE'(avail)) ? to_recv[2:0] : avail;
    beat_sh = beat >> {drop, 3'b000};
    acc_app = acc;
    for (int i = 0; i < ACC_B; i++) begin
      for (int j = 0; j < PHY_B; j++) begin
        if (j < int'(app) && i == int'(fill) + j) acc_app[8*i +: 8] = beat_sh[8*j +: 8];
      end
    end
    total   = fill + {1'b0, app};
    recv_nx = to_recv - TRANS_SIZE'(app);
    moved   = (total >= 4'd4) ? 4'd4 : total;
    emit    = (state != IDLE) && !abort_hit &&
              ((total >= 4'd4) || (recv_nx == '0 && total != 4'd0)) &&
              (!dst_valid_o || dst_ready_i);
    last_w  = (rem == TRANS_SIZE'(moved));
    fill_nx = emit ? (total - moved) : total;
    acc_nx  = emit ? (acc_app >> 32) : acc_app;
  end

  // Transfer sequencing: start, end of reception, final handshake, abort
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    start_ok = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start_i) begin
          start_ok = 1'b1;
          if (cfg_rx_size_i != '0) state_nx = RUN;
          else                     done_nx  = 1'b1;
        end
      end
      RUN: begin
        if (recv_nx == '0) state_nx = DRAIN;
      end
      DRAIN: begin
        if (dst_valid_o && dst_ready_i && dst_last_o) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort_hit) begin
      state_nx = IDLE;
      done_nx  = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Accumulator, counters and latched configuration
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc     <= '0;
      fill    <= '0;
      skip    <= '0;
      to_recv <= '0;
      rem     <= '0;
      swap_q  <= SWAP_DEF;
    end else if (start_ok) begin
      acc     <= '0;
      fill    <= '0;
      skip    <= cfg_offset_i;
      to_recv <= cfg_rx_size_i;
      rem     <= cfg_rx_size_i;
      swap_q  <= cfg_swap_i;
    end else if (abort_hit) begin
      acc     <= '0;
      fill    <= '0;
      skip    <= '0;
      to_recv <= '0;
      rem     <= '0;
    end else if (state != IDLE) begin
      acc     <= acc_nx;
      fill    <= fill_nx;
      to_recv <= recv_nx;
      if (accept) skip <= skip - drop[1:0];
      if (emit)   rem  <= rem - TRANS_SIZE'(moved);
    end
  end

  // Registered handshake/status outputs and the output word stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      dst_valid_o <= 1'b0;
      dst_data_o  <= '0;
      dst_last_o  <= 1'b0;
    end else begin
      src_ready_o <= (state_nx == RUN) && (start_ok || fill_nx <= 4'd4);
      busy_o      <= (state_nx != IDLE);
      done_o      <= done_nx;
      if (abort_hit) begin
        dst_valid_o <= 1'b0;
        dst_last_o  <= 1'b0;
      end else if (emit) begin
        dst_valid_o <= 1'b1;
        dst_data_o  <= acc_app[31:0];
        dst_last_o  <= last_w;
      end else if (dst_ready_i) begin
        dst_valid_o <= 1'b0;
        dst_last_o  <= 1'b0;
      end
    end
  end

`ifdef UDMA_RX_ALIGNER_ABORT_EN
  // Abort indication travels with its done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) abort_o <= 1'b0;
    else       abort_o <= abort_hit;
  end
`endif

endmodule

// File: tb/tb_udma_rx_aligner.sv
// tb/tb_udma_rx_aligner.sv - self-checking bench for udma_rx_aligner (PHY_W 16, 8 and 32 instances)
`timescale 1ns/1ps
module tb_udma_rx_aligner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cfg_start [3];
  logic [15:0] cfg_size  [3];
  logic [1:0]  cfg_off   [3];
  logic        cfg_swap  [3];
  logic        src_valid [3];
  logic        src_ready [3];
  logic [31:0] src_data  [3];
  logic        dst_valid [3];
  logic        dst_ready [3];
  logic [31:0] dst_data  [3];
  logic        dst_last  [3];
  logic        busy      [3];
  logic        done      [3];
`ifdef UDMA_RX_ALIGNER_ABORT_EN
  logic        cfg_abort [3];
  logic        abort_s   [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 32;
    udma_rx_aligner #(.TRANS_SIZE(16), .PHY_W(W), .SWAP_DEF(1'b0)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cfg_start_i   (cfg_start[g]),
      .cfg_rx_size_i (cfg_size[g]),
      .cfg_offset_i  (cfg_off[g]),
      .cfg_swap_i    (cfg_swap[g]),
`ifdef UDMA_RX_ALIGNER_ABORT_EN
      .cfg_abort_i   (cfg_abort[g]),
      .abort_o       (abort_s[g]),
`endif
      .src_valid_i   (src_valid[g]),
      .src_ready_o   (src_ready[g]),
      .src_data_i    (src_data[g][W-1:0]),
      .dst_valid_o   (dst_valid[g]),
      .dst_ready_i   (dst_ready[g]),
      .dst_data_o    (dst_data[g]),
      .dst_last_o    (dst_last[g]),
      .busy_o        (busy[g]),
      .done_o        (done[g])
    );
  end

  int          n_chk = 0;
  int          n_pass = 0;
  int          cur = 0;
  int          words_seen = 0;
  int          done_cnt = 0;
  logic [32:0] exp_q[$];
  logic [31:0] beats[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: serialise beats into a byte stream, drop offset, keep size bytes, cut into padded words
  task automatic build_model(input int pb, input int nbeats, input int size, input int off, input bit swap);
    logic [7:0] bq[$];
    logic [31:0] w;
    int s;
    for (int i = 0; i < nbeats; i++) begin
      for (int b = 0; b < pb; b++) begin
        s = swap ? (pb - 1 - b) : b;
        bq.push_back(beats[i][8*s +: 8]);
      end
    end
    for (int k = 0; k < off; k++) void'(bq.pop_front());
    for (int k = 0; k < size; k += 4) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) if (k + b < size) w[8*b +: 8] = bq[k+b];
      exp_q.push_back({(k + 4 >= size), w});
    end
  endtask

  // Output checker: every handshaken word against the reference, held words stable, done after last
  logic        prev_hold = 1'b0;
  logic [32:0] prev_word = '0;
  logic        done_due = 1'b0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      done_due  = 1'b0;
    end else begin
      if (done_due) begin
        check("done_after_last", {63'd0, done[cur]}, 64'd1);
        done_due = 1'b0;
      end
      if (done[cur]) done_cnt++;
      if (prev_hold && dst_valid[cur])
        check("held_word_stable", {31'd0, dst_last[cur], dst_data[cur]}, {31'd0, prev_word});
      if (dst_valid[cur] && dst_ready[cur]) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got %h expected none", dst_data[cur]);
        end else begin
          e = exp_q.pop_front();
          check("word", {31'd0, dst_last[cur], dst_data[cur]}, {31'd0, e});
          if (e[32]) done_due = 1'b1;
        end
        words_seen++;
      end
      prev_hold = dst_valid[cur] && !dst_ready[cur];
      prev_word = {dst_last[cur], dst_data[cur]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int g, input int size, input int off, input bit swap);
    cfg_size[g]  = 16'(size);
    cfg_off[g]   = 2'(off);
    cfg_swap[g]  = swap;
    cfg_start[g] = 1'b1;
    tick();
    cfg_start[g] = 1'b0;
  endtask

  task automatic feed(input int g, input int n, output int cyc);
    int i;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 100) begin
      src_valid[g] = 1'b1;
      src_data[g]  = beats[i];
      @(negedge clk);
      if (src_ready[g]) i++;
      tick();
      cyc++;
    end
    src_valid[g] = 1'b0;
    check("beats_accepted", 64'(i), 64'(n));
  endtask

  task automatic finish_xfer(input int target, input int done_base);
    int t;
    t = 0;
    while (words_seen < target && t < 200) begin
      tick();
      t++;
    end
    check("word_count", 64'(words_seen), 64'(target));
    repeat (3) tick();
    check("done_pulses", 64'(done_cnt - done_base), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_idle", {63'd0, busy[cur]}, 64'd0);
  endtask

  int cyc, base_w, base_d, t;

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cfg_start[g] = 0; cfg_size[g] = 0; cfg_off[g] = 0; cfg_swap[g] = 0;
      src_valid[g] = 0; src_data[g] = 0; dst_ready[g] = 1;
`ifdef UDMA_RX_ALIGNER_ABORT_EN
      cfg_abort[g] = 0;
`endif
    end
    #12;
    for (int g = 0; g < 3; g++)
      check($sformatf("reset_outputs_%0d", g),
            {26'd0, dst_valid[g], dst_data[g], dst_last[g], src_ready[g], busy[g], done[g]}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // PHY16, size 8, no offset
    cur = 0;
    beats[0] = 32'h1100; beats[1] = 32'h3322; beats[2] = 32'h5544; beats[3] = 32'h7766;
    build_model(2, 4, 8, 0, 0);
    check("model_t1_w0", {31'd0, exp_q[0]}, {31'd0, 1'b0, 32'h33221100});
    check("model_t1_w1", {31'd0, exp_q[1]}, {31'd0, 1'b1, 32'h77665544});
    base_w = words_seen; base_d = done_cnt;
    start_xfer(0, 8, 0, 0);
    feed(0, 4, cyc);
    finish_xfer(base_w + 2, base_d);

    // PHY16, size 5, offset 1: ready falls after the third beat
    build_model(2, 4, 5, 1, 0);
    check("model_t2_w0", {31'd0, exp_q[0]}, {31'd0, 1'b0, 32'h44332211});
    check("model_t2_w1", {31'd0, exp_q[1]}, {31'd0, 1'b1, 32'h00000055});
    base_w = words_seen; base_d = done_cnt;
    start_xfer(0, 5, 1, 0);
    feed(0, 3, cyc);
    check("t2_ready_drop", {63'd0, src_ready[0]}, 64'd0);
    finish_xfer(base_w + 2, base_d);

    // PHY8, size 3, offset 3: three whole beats dropped, later beats refused
    cur = 1;
    for (int i = 0; i < 7; i++) beats[i] = 32'hA0 + 32'(i);
    build_model(1, 7, 3, 3, 0);
    check("model_t3_w0", {31'd0, exp_q[0]}, {31'd0, 1'b1, 32'h00A5A4A3});
    base_w = words_seen; base_d = done_cnt;
    start_xfer(1, 3, 3, 0);
    feed(1, 6, cyc);
    src_valid[1] = 1'b1; src_data[1] = beats[6];
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_extra_refused", {63'd0, src_ready[1]}, 64'd0);
      tick();
    end
    src_valid[1] = 1'b0;
    finish_xfer(base_w + 1, base_d);

    // PHY32, size 12, swap, second word stalled five cycles
    cur = 2;
    beats[0] = 32'h00112233; beats[1] = 32'h44556677; beats[2] = 32'h8899AABB;
    build_model(4, 3, 12, 0, 1);
    check("model_t4_w0", {31'd0, exp_q[0]}, {31'd0, 1'b0, 32'h33221100});
    check("model_t4_w2", {31'd0, exp_q[2]}, {31'd0, 1'b1, 32'hBBAA9988});
    base_w = words_seen; base_d = done_cnt;
    start_xfer(2, 12, 0, 1);
    fork
      feed(2, 3, cyc);
      begin
        t = 0;
        while (!(words_seen == base_w + 1 && dst_valid[2]) && t < 50) begin
          tick();
          t++;
        end
        check("t4_stall_reached", 64'(t < 50), 64'd1);
        dst_ready[2] = 1'b0;
        repeat (5) tick();
        dst_ready[2] = 1'b1;
      end
    join
    check("t4_no_src_stall", 64'(cyc), 64'd3);
    finish_xfer(base_w + 3, base_d);

    // Reset mid-transfer with a word held at the output
    cur = 0;
    beats[0] = 32'h1100; beats[1] = 32'h3322; beats[2] = 32'h5544; beats[3] = 32'h7766;
    dst_ready[0] = 1'b0;
    start_xfer(0, 8, 0, 0);
    feed(0, 2, cyc);
    check("rst_word_pending", {63'd0, dst_valid[0]}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clear", {27'd0, dst_valid[0], dst_data[0], dst_last[0], src_ready[0], busy[0], done[0]}, 64'd0);
    base_d = done_cnt;
    tick();
    rst = 1'b0;
    dst_ready[0] = 1'b1;
    repeat (3) tick();
    check("rst_no_done", 64'(done_cnt - base_d), 64'd0);
    check("rst_busy", {63'd0, busy[0]}, 64'd0);

    // Zero-length transfer
    start_xfer(0, 0, 0, 0);
    check("size0_done", {62'd0, done[0], dst_valid[0]}, 64'd2);
    check("size0_busy", {63'd0, busy[0]}, 64'd0);
    tick();
    check("size0_done_single", {63'd0, done[0]}, 64'd0);

`ifdef UDMA_RX_ALIGNER_ABORT_EN
    // Abort with the first word of a 16-byte transfer held, then a fresh transfer
    dst_ready[0] = 1'b0;
    start_xfer(0, 16, 0, 0);
    feed(0, 2, cyc);
    check("abort_word_pending", {63'd0, dst_valid[0]}, 64'd1);
    cfg_abort[0] = 1'b1;
    tick();
    cfg_abort[0] = 1'b0;
    check("abort_response", {60'd0, dst_valid[0], abort_s[0], done[0], busy[0]}, 64'b0110);
    dst_ready[0] = 1'b1;
    tick();
    build_model(2, 2, 4, 0, 0);
    base_w = words_seen; base_d = done_cnt;
    start_xfer(0, 4, 0, 0);
    feed(0, 2, cyc);
    finish_xfer(base_w + 1, base_d);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
